// File: rtl/cpu_fetch_pkg.sv
// Shared constants for the fetch datapath: control-word bit masks, IR field
// positions and the decoded micro-operation view of a control word.
package cpu_fetch_pkg;

    localparam int unsigned CTRL_W = 15;

    // Control-word masks (one bit per micro-operation; bits 7:0 are unused here)
    localparam logic [CTRL_W-1:0] CTRL_C  = 15'h4000;  // increment PC
    localparam logic [CTRL_W-1:0] CTRL_EP = 15'h2000;  // PC onto bus
    localparam logic [CTRL_W-1:0] CTRL_LM = 15'h1000;  // load MAR from bus
    localparam logic [CTRL_W-1:0] CTRL_EM = 15'h0800;  // memory onto bus
    localparam logic [CTRL_W-1:0] CTRL_LI = 15'h0400;  // load IR from bus
    localparam logic [CTRL_W-1:0] CTRL_EI = 15'h0200;  // IR operand onto bus
    localparam logic [CTRL_W-1:0] CTRL_LP = 15'h0100;  // load PC from bus

    // IR field positions, shared with the control unit
    localparam int unsigned IR_OPCODE_MSB  = 7;
    localparam int unsigned IR_OPCODE_LSB  = 4;
    localparam int unsigned IR_OPERAND_MSB = 3;
    localparam int unsigned IR_OPERAND_LSB = 0;

    typedef struct packed {
        logic c;
        logic ep;
        logic lm;
        logic em;
        logic li;
        logic ei;
        logic lp;
    } uops_t;

    // Which source this block places on the shared bus
    typedef enum logic [1:0] {
        SRC_NONE    = 2'd0,
        SRC_PC      = 2'd1,
        SRC_OPERAND = 2'd2,
        SRC_MEM     = 2'd3
    } bus_src_e;

    function automatic uops_t decode_uops(input logic [CTRL_W-1:0] cw);
        uops_t u;
        u.c  = |(cw & CTRL_C);
        u.ep = |(cw & CTRL_EP);
        u.lm = |(cw & CTRL_LM);
        u.em = |(cw & CTRL_EM);
        u.li = |(cw & CTRL_LI);
        u.ei = |(cw & CTRL_EI);
        u.lp = |(cw & CTRL_LP);
        return u;
    endfunction

    // True when more than one bus driver is requested at once
    function automatic logic bus_conflict(input uops_t u);
        return (u.em & u.ei) | (u.em & u.ep) | (u.ei & u.ep);
    endfunction

endpackage

// File: rtl/cpu_fetch_pc.sv
// Program counter: loadable, incrementing, wraps modulo 2^ADDR_W.
// Load takes priority over increment when both are requested.
module cpu_fetch_pc #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next PC: load wins over increment, otherwise hold
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    // PC register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_fetch.sv
// Fetch-side datapath: PC, MAR and IR, executing the fetch/jump
// micro-operations selected by the control word. Pure register/micro-op
// executor; T-state sequencing lives in the control unit.
// Optional build macro: BUS_CONFLICT_CHECK_EN (sticky multiple-driver flag).
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ICNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] control_lines,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [3:0]        reg_ir,
    output logic [3:0]        operand,
    output logic [ADDR_W-1:0] pc,
    output logic [ICNT_W-1:0] icount,
    output logic              bus_err
);

    uops_t             uop;
    bus_src_e          bus_src;
    logic [ADDR_W-1:0] pc_val;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              unused_ctrl;

    assign uop         = decode_uops(control_lines);
    assign unused_ctrl = ^control_lines[7:0];

    cpu_fetch_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (uop.lp),
        .inc_i      (uop.c),
        .load_val_i (bus_in[ADDR_W-1:0]),
        .pc_o       (pc_val)
    );

    // Bus source select with fixed priority EM > EI > EP
    always_comb begin
        bus_src = SRC_NONE;
        if (uop.em) begin
            bus_src = SRC_MEM;
        end else if (uop.ei) begin
            bus_src = SRC_OPERAND;
        end else if (uop.ep) begin
            bus_src = SRC_PC;
        end
    end

    // Bus output value for the selected source
    always_comb begin
        bus_out = '0;
        unique case (bus_src)
            SRC_MEM:     bus_out = mem_data;
            SRC_OPERAND: bus_out = DATA_W'(ir_q[IR_OPERAND_MSB:IR_OPERAND_LSB]);
            SRC_PC:      bus_out = DATA_W'(pc_val);
            default:     bus_out = '0;
        endcase
    end

    assign bus_drive = (bus_src != SRC_NONE);

    // Next-state for MAR, IR and the fetched-instruction counter
    always_comb begin
        mar_d  = mar_q;
        ir_d   = ir_q;
        icnt_d = icnt_q;
        if (uop.lm) begin
            mar_d = bus_in[ADDR_W-1:0];
        end
        if (uop.li) begin
            ir_d   = bus_in;
            icnt_d = icnt_q + ICNT_W'(1);
        end
    end

    // MAR / IR / counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mar_q  <= '0;
            ir_q   <= '0;
            icnt_q <= '0;
        end else begin
            mar_q  <= mar_d;
            ir_q   <= ir_d;
            icnt_q <= icnt_d;
        end
    end

    assign mem_addr = mar_q;
    assign mem_rd   = uop.em;
    assign reg_ir   = ir_q[IR_OPCODE_MSB:IR_OPCODE_LSB];
    assign operand  = ir_q[IR_OPERAND_MSB:IR_OPERAND_LSB];
    assign pc       = pc_val;
    assign icount   = icnt_q;

`ifdef BUS_CONFLICT_CHECK_EN
    logic bus_err_q;

    // Sticky flag: set on any edge with more than one bus driver requested
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_q <= 1'b0;
        end else if (bus_conflict(uop)) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q;

`ifndef SYNTHESIS
    // Simulation-only warning on each conflicting edge
    always @(posedge clk) begin
        if (rst && bus_conflict(uop)) begin
            $display("cpu_fetch warning: bus conflict pc=%0h control=%h", pc_val, control_lines);
        end
    end
`endif
`else
    assign bus_err = 1'b0;
`endif

endmodule
